// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter driving the write port of one synchronous FIFO.
// Optional idle-grant watchdog with timeout_err output: define FIFO_ARB_TIMEOUT_EN.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 16,
   localparam int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_w_en,
   output logic [DATA_WIDTH-1:0]         fifo_w_data,
`ifdef FIFO_ARB_TIMEOUT_EN
   output logic                          timeout_err,
`endif
   output logic                          gnt_valid,
   output logic [IW-1:0]                 gnt_id
);

   if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_bad_param
      $error("fifo_wr_arbiter: illegal parameter value");
   end

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t          state_q;
   logic            gnt_valid_q;
   logic [IW-1:0]   gnt_id_q;
   logic [IW-1:0]   rr_ptr_q;
   logic            any_valid_s;
   logic [IW-1:0]   pick_id_s;
   logic [IW-1:0]   next_ptr_s;
   logic            beat_s;
   logic            last_s;
   logic [DATA_WIDTH-1:0] holder_data_s;

`ifdef FIFO_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]   idle_cnt_q;
   logic            timeout_err_q;
`endif

   // Lowest offset from ptr wins; scanning downward lets the last hit be the winner.
   function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [IW-1:0] ptr);
      logic [IW-1:0] sel;
      int            idx;
      sel = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         idx = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
         if (v[idx]) sel = IW'(idx);
         else        sel = sel;
      end
      return sel;
   endfunction

   assign any_valid_s   = |req_valid;
   assign pick_id_s     = rr_pick(req_valid, rr_ptr_q);
   assign next_ptr_s    = (gnt_id_q == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : (gnt_id_q + IW'(1));
   assign holder_data_s = req_data[int'(gnt_id_q)*DATA_WIDTH +: DATA_WIDTH];
   assign beat_s        = fifo_w_en;
   assign last_s        = req_last[gnt_id_q];
   assign gnt_valid     = gnt_valid_q;
   assign gnt_id        = gnt_id_q;
`ifdef FIFO_ARB_TIMEOUT_EN
   assign timeout_err   = timeout_err_q;
`endif

   // Write-port steering: only the grant holder sees ready, zero-latency pass-through.
   always_comb begin
      req_ready   = {NUM_REQ{1'b0}};
      fifo_w_en   = 1'b0;
      fifo_w_data = {DATA_WIDTH{1'b0}};
      if (state_q == LOCK) begin
         req_ready[gnt_id_q] = ~fifo_full;
         fifo_w_en           = req_valid[gnt_id_q] & ~fifo_full;
      end else begin
         fifo_w_en = 1'b0;
      end
      if (gnt_valid_q) fifo_w_data = holder_data_s;
      else             fifo_w_data = {DATA_WIDTH{1'b0}};
   end

   // Grant FSM: pick in IDLE, hold in LOCK until the last beat (or watchdog) releases it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= {IW{1'b0}};
         rr_ptr_q    <= {IW{1'b0}};
`ifdef FIFO_ARB_TIMEOUT_EN
         idle_cnt_q    <= {CW{1'b0}};
         timeout_err_q <= 1'b0;
`endif
      end else begin
`ifdef FIFO_ARB_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (any_valid_s) begin
                  gnt_id_q    <= pick_id_s;
                  gnt_valid_q <= 1'b1;
                  state_q     <= LOCK;
               end else begin
                  gnt_valid_q <= 1'b0;
               end
            end
            LOCK: begin
`ifdef FIFO_ARB_TIMEOUT_EN
               if (beat_s && last_s) begin
                  state_q     <= IDLE;
                  gnt_valid_q <= 1'b0;
                  rr_ptr_q    <= next_ptr_s;
                  idle_cnt_q  <= {CW{1'b0}};
               end else if (beat_s) begin
                  idle_cnt_q <= {CW{1'b0}};
               end else if (!req_valid[gnt_id_q]) begin
                  // The TIMEOUT-th consecutive idle cycle releases the grant.
                  if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
                     state_q       <= IDLE;
                     gnt_valid_q   <= 1'b0;
                     rr_ptr_q      <= next_ptr_s;
                     idle_cnt_q    <= {CW{1'b0}};
                     timeout_err_q <= 1'b1;
                  end else begin
                     idle_cnt_q <= idle_cnt_q + CW'(1);
                  end
               end else begin
                  idle_cnt_q <= idle_cnt_q;
               end
`else
               if (beat_s && last_s) begin
                  state_q     <= IDLE;
                  gnt_valid_q <= 1'b0;
                  rr_ptr_q    <= next_ptr_s;
               end else begin
                  state_q <= LOCK;
               end
`endif
            end
            default: begin
               state_q     <= IDLE;
               gnt_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios then randomized traffic, checked
// against a packet-queue reference model and an 8-deep FIFO occupancy model.
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_last;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            fifo_full;
   logic            fifo_w_en;
   logic [DW-1:0]   fifo_w_data;
   logic            gnt_valid;
   logic [1:0]      gnt_id;
`ifdef FIFO_ARB_TIMEOUT_EN
   logic            timeout_err;
`endif

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full),
      .fifo_w_en(fifo_w_en), .fifo_w_data(fifo_w_data),
`ifdef FIFO_ARB_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .gnt_valid(gnt_valid), .gnt_id(gnt_id)
   );

   // Producer packet queues: {last, data} per beat.
   logic [8:0] pq [N][$];
   int  gap [N];
   int  occ, rd_mode, n_chk, n_fail, cyc, beats_in;
   bit  force_full, rand_gaps, prev_gv;
   bit  m_gv, m_terr;
   int  m_id, m_rr, m_tcnt;
   int  wl_dat[$], wl_cyc[$], g_id[$], g_cyc[$], gfall_cyc[$], t_cyc[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin pq[i].delete(); gap[i] = 0; end
      m_gv = 1'b0; m_terr = 1'b0; m_id = 0; m_rr = 0; m_tcnt = 0;
      occ = 0; force_full = 1'b0; prev_gv = 1'b0;
      wl_dat.delete(); wl_cyc.delete(); g_id.delete(); g_cyc.delete();
      gfall_cyc.delete(); t_cyc.delete();
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (pq[i].size() > 0) begin
            req_valid[i]          = (gap[i] == 0);
            req_data[i*DW +: DW]  = pq[i][0][7:0];
            req_last[i]           = pq[i][0][8];
         end else begin
            req_valid[i]          = 1'b0;
            req_data[i*DW +: DW]  = 8'h00;
            req_last[i]           = 1'b0;
         end
      end
      fifo_full = force_full || (occ >= 8);
   endtask

   task automatic check();
      logic [N-1:0]  e_rdy;
      logic          e_wen;
      logic [DW-1:0] e_dat;
      e_rdy = '0; e_wen = 1'b0; e_dat = 8'h00;
      if (m_gv) begin
         e_rdy[m_id] = !fifo_full;
         e_wen       = req_valid[m_id] && !fifo_full;
         e_dat       = (pq[m_id].size() > 0) ? pq[m_id][0][7:0] : 8'h00;
         chk("gnt_id", gnt_id, m_id);
      end
      chk("gnt_valid", gnt_valid, m_gv);
      chk("req_ready", req_ready, e_rdy);
      chk("fifo_w_en", fifo_w_en, e_wen);
      chk("fifo_w_data", fifo_w_data, e_dat);
      chk("write_when_full", fifo_w_en && fifo_full, 1'b0);
`ifdef FIFO_ARB_TIMEOUT_EN
      chk("timeout_err", timeout_err, m_terr);
      if (timeout_err) t_cyc.push_back(cyc);
`endif
      if (gnt_valid && !prev_gv) begin g_id.push_back(gnt_id); g_cyc.push_back(cyc); end
      if (!gnt_valid && prev_gv) gfall_cyc.push_back(cyc);
      prev_gv = gnt_valid;
      if (fifo_w_en) begin wl_dat.push_back(fifo_w_data); wl_cyc.push_back(cyc); end
   endtask

   task automatic update();
      bit rel, wr, rd, terr_next;
      rel = 1'b0; wr = 1'b0; terr_next = 1'b0;
      for (int i = 0; i < N; i++) if (gap[i] > 0) gap[i]--;
      if (m_gv && req_valid[m_id] && !fifo_full) begin
         wr = 1'b1;
         if (pq[m_id][0][8]) rel = 1'b1;
         void'(pq[m_id].pop_front());
         if (rand_gaps) gap[m_id] = $urandom_range(0, 2);
         m_tcnt = 0;
      end else if (m_gv && !req_valid[m_id]) begin
         m_tcnt++;
`ifdef FIFO_ARB_TIMEOUT_EN
         if (m_tcnt == TO) begin rel = 1'b1; terr_next = 1'b1; end
`endif
      end
      rd  = ((rd_mode == 1) || (rd_mode == 2 && $urandom_range(0, 1) == 1)) && (occ > 0);
      occ = occ + int'(wr) - int'(rd);
      m_terr = terr_next;
      if (!m_gv) begin
         if (|req_valid) begin
            m_gv = 1'b1;
            for (int k = N - 1; k >= 0; k--) if (req_valid[(m_rr + k) % N]) m_id = (m_rr + k) % N;
         end
      end else if (rel) begin
         m_gv = 1'b0; m_rr = (m_id + 1) % N; m_tcnt = 0;
      end
   endtask

   task automatic step();
      drive(); #1; cyc++; check(); update();
      @(posedge clk); #1;
   endtask

   // Asserts rst off the clock edge, checks outputs fall at once, then releases it.
   task automatic do_reset();
      rst = 1'b0; #1;
      chk("rst_w_en", fifo_w_en, 1'b0);
      chk("rst_ready", req_ready, 4'b0000);
      chk("rst_gnt_valid", gnt_valid, 1'b0);
      clear_model(); drive(); #3;
      rst = 1'b1;
   endtask

   task automatic push_pkt(input int r, input int len, input int base);
      for (int b = 0; b < len; b++) pq[r].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'(base + b)});
   endtask

   initial begin
      int c0, empty;
      n_chk = 0; n_fail = 0; cyc = 0; rd_mode = 1; rand_gaps = 1'b0; beats_in = 0;
      clear_model(); drive();
      rst = 1'b0;
      #10;
      chk("reset_gnt_valid", gnt_valid, 1'b0);
      chk("reset_gnt_id", gnt_id, 2'd0);
      chk("reset_w_en", fifo_w_en, 1'b0);
      chk("reset_ready", req_ready, 4'b0000);
      chk("reset_w_data", fifo_w_data, 8'h00);
      #10 rst = 1'b1;

      // Single 3-beat packet from requester 2.
      pq[2].push_back({1'b0, 8'hAA}); pq[2].push_back({1'b0, 8'hBB}); pq[2].push_back({1'b1, 8'hCC});
      c0 = cyc + 1;
      repeat (6) step();
      chk("single_nbeats", wl_dat.size(), 3);
      chk("single_ngrants", g_id.size(), 1);
      if (wl_dat.size() == 3 && g_id.size() == 1 && gfall_cyc.size() >= 1) begin
         chk("single_b0", wl_dat[0], 8'hAA);
         chk("single_b1", wl_dat[1], 8'hBB);
         chk("single_b2", wl_dat[2], 8'hCC);
         chk("single_contig", wl_cyc[2] - wl_cyc[0], 2);
         chk("single_gnt_id", g_id[0], 2);
         chk("single_latency", g_cyc[0] - c0, 1);
         chk("single_release", gfall_cyc[0] - wl_cyc[2], 1);
      end

      // Round robin with 1-beat packets from every requester.
      do_reset();
      push_pkt(0, 1, 8'h10); push_pkt(0, 1, 8'h50);
      push_pkt(1, 1, 8'h20); push_pkt(2, 1, 8'h30); push_pkt(3, 1, 8'h40);
      repeat (14) step();
      chk("rr_ngrants", g_id.size(), 5);
      if (g_id.size() == 5) begin
         for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), g_id[k], k % 4);
         for (int k = 1; k < 5; k++) chk($sformatf("rr_bubble%0d", k), g_cyc[k] - g_cyc[k-1], 2);
      end

      // Packet atomicity against a competing requester.
      do_reset();
      push_pkt(0, 4, 8'h01); push_pkt(1, 1, 8'h80);
      repeat (10) step();
      chk("atom_nbeats", wl_dat.size(), 5);
      if (wl_dat.size() == 5) begin
         for (int k = 0; k < 4; k++) chk($sformatf("atom_b%0d", k), wl_dat[k], k + 1);
         chk("atom_contig", wl_cyc[3] - wl_cyc[0], 3);
         chk("atom_other", wl_dat[4], 8'h80);
      end

      // Forced full for 5 cycles mid-packet.
      do_reset();
      push_pkt(3, 6, 8'h30);
      for (int k = 0; k < 10 && wl_dat.size() < 2; k++) step();
      force_full = 1'b1;
      repeat (5) step();
      chk("full_nowrite", wl_dat.size(), 2);
      chk("full_hold_gnt", gnt_valid, 1'b1);
      force_full = 1'b0;
      repeat (8) step();
      chk("full_nbeats", wl_dat.size(), 6);
      if (wl_dat.size() == 6)
         for (int k = 0; k < 6; k++) chk($sformatf("full_b%0d", k), wl_dat[k], 8'h30 + k);

      // Fill the 8-deep FIFO with no reads, then drain.
      do_reset();
      rd_mode = 0;
      push_pkt(1, 10, 8'h40);
      repeat (14) step();
      chk("fill_writes", wl_dat.size(), 8);
      rd_mode = 1;
      repeat (10) step();
      chk("fill_total", wl_dat.size(), 10);
      if (wl_dat.size() == 10) chk("fill_last", wl_dat[9], 8'h49);

      // Asynchronous reset between beats 2 and 3; arbitration must restart at 0.
      do_reset();
      push_pkt(1, 1, 8'h99); push_pkt(2, 4, 8'h11);
      for (int k = 0; k < 12 && wl_dat.size() < 3; k++) step();
      drive(); #2;
      chk("pre_reset_w_en", fifo_w_en, 1'b1);
      do_reset();
      push_pkt(0, 1, 8'h55); push_pkt(3, 1, 8'h66);
      repeat (8) step();
      chk("arst_ngrants", g_id.size(), 2);
      if (g_id.size() == 2) begin
         chk("arst_first", g_id[0], 0);
         chk("arst_second", g_id[1], 3);
      end

`ifdef FIFO_ARB_TIMEOUT_EN
      // Holder goes silent after one beat; watchdog releases the grant.
      do_reset();
      push_pkt(1, 3, 8'hE0); push_pkt(2, 1, 8'h77);
      for (int k = 0; k < 6 && wl_dat.size() < 1; k++) step();
      gap[1] = 40;
      repeat (24) step();
      chk("to_pulses", t_cyc.size(), 1);
      chk("to_next_gnt", (g_id.size() >= 2) ? g_id[1] : 99, 2);
      gap[1] = 0;
      repeat (12) step();
`endif

      // Randomized traffic with random reads and producer gaps, then drain.
      do_reset();
      rand_gaps = 1'b1; rd_mode = 2; beats_in = 0;
      repeat (400) begin
         for (int i = 0; i < N; i++)
            if (pq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
               int len;
               len = $urandom_range(1, 5);
               push_pkt(i, len, $urandom_range(0, 255));
               beats_in += len;
            end
         step();
      end
      rd_mode = 1;
      empty = 0;
      for (int k = 0; k < 500 && empty == 0; k++) begin
         step();
         empty = (pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() == 0) ? 1 : 0;
      end
      chk("rand_drained", empty, 1);
      chk("rand_beat_count", wl_dat.size(), beats_in);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
